// File: rtl/nonce_tx_arbiter.sv
// Round-robin arbiter sharing the serial_transmit nonce uplink between SLAVES sources.
// Optional duplicate suppression of back-to-back identical nonces: define NONCE_DEDUP_EN.
module nonce_tx_arbiter #(
    parameter int unsigned SLAVES       = 2,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SLAVES*32-1:0]     slave_nonces,
    input  logic [SLAVES-1:0]        new_nonces,
    input  logic                     serial_busy,
    output logic [31:0]              golden_nonce,
    output logic                     serial_send,
    output logic [SLAVES-1:0]        pending,
    output logic [SLAVES-1:0]        overflow
);

    localparam int unsigned NW = 32;
    localparam int unsigned GW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NW-1:0]     golden_nonce_q, golden_nonce_d;
    logic              serial_send_q, serial_send_d;
    logic [SLAVES-1:0] pending_q, pending_d;
    logic [SLAVES-1:0] overflow_q, overflow_d;
    logic [NW-1:0]     nonce_buf_q [SLAVES];
    logic [NW-1:0]     nonce_buf_d [SLAVES];

`ifdef NONCE_DEDUP_EN
    logic [NW-1:0]     last_sent_q, last_sent_d;
    logic              last_sent_vld_q, last_sent_vld_d;
`endif

    logic              grant_vld_c;
    logic [GW-1:0]     grant_idx_c;
    logic              do_grant;
    logic              tx_grant;
    logic [SLAVES-1:0] grant_mask;

    // Cyclic scan: first pending source strictly after the last one granted.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 1; k <= SLAVES; k++) begin
            int unsigned idx;
            idx = (32'(last_grant_q) + k) % SLAVES;
            if (!grant_vld_c && pending_q[idx]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        timer_d        = timer_q;
        golden_nonce_d = golden_nonce_q;
        pending_d      = pending_q;
        overflow_d     = overflow_q;
        nonce_buf_d    = nonce_buf_q;
        do_grant       = 1'b0;
        tx_grant       = 1'b0;
        grant_mask     = '0;
`ifdef NONCE_DEDUP_EN
        last_sent_d     = last_sent_q;
        last_sent_vld_d = last_sent_vld_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_vld_c && !serial_busy) begin
                    do_grant     = 1'b1;
                    last_grant_d = grant_idx_c;
`ifdef NONCE_DEDUP_EN
                    // A repeat of the last transmitted word is retired without a send.
                    tx_grant = !(last_sent_vld_q && (nonce_buf_q[grant_idx_c] == last_sent_q));
                    if (tx_grant) begin
                        last_sent_d     = nonce_buf_q[grant_idx_c];
                        last_sent_vld_d = 1'b1;
                    end
`else
                    tx_grant = 1'b1;
`endif
                    if (tx_grant) begin
                        golden_nonce_d = nonce_buf_q[grant_idx_c];
                        state_d        = SEND;
                    end
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (serial_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            grant_mask = SLAVES'(1) << grant_idx_c;
        end
        pending_d = pending_q & ~grant_mask;

        // A source granted on this edge frees its buffer, so its new strobe is kept.
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) begin
                if (!pending_q[i] || grant_mask[i]) begin
                    nonce_buf_d[i] = slave_nonces[i*NW +: NW];
                    pending_d[i]   = 1'b1;
                end else begin
                    overflow_d[i]  = 1'b1;
                end
            end
        end

        serial_send_d = (state_d == SEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= GW'(SLAVES - 1);
            timer_q        <= '0;
            golden_nonce_q <= '0;
            serial_send_q  <= 1'b0;
            pending_q      <= '0;
            overflow_q     <= '0;
            for (int unsigned i = 0; i < SLAVES; i++) begin
                nonce_buf_q[i] <= '0;
            end
`ifdef NONCE_DEDUP_EN
            last_sent_q     <= '0;
            last_sent_vld_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            timer_q        <= timer_d;
            golden_nonce_q <= golden_nonce_d;
            serial_send_q  <= serial_send_d;
            pending_q      <= pending_d;
            overflow_q     <= overflow_d;
            nonce_buf_q    <= nonce_buf_d;
`ifdef NONCE_DEDUP_EN
            last_sent_q     <= last_sent_d;
            last_sent_vld_q <= last_sent_vld_d;
`endif
        end
    end

    assign golden_nonce = golden_nonce_q;
    assign serial_send  = serial_send_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Scoreboard bench for nonce_tx_arbiter: expected words queued at strobe time,
// popped and compared on every serial_send pulse.
module tb_nonce_tx_arbiter;

    localparam int unsigned SLAVES = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [SLAVES*32-1:0] slave_nonces;
    logic [SLAVES-1:0]    new_nonces;
    logic                 serial_busy;
    logic [31:0]          golden_nonce;
    logic                 serial_send;
    logic [SLAVES-1:0]    pending;
    logic [SLAVES-1:0]    overflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned n_sends = 0;
    logic        busy_en = 1'b1;
    logic [31:0] exp_q[$];
    int unsigned send_cyc[$];

    nonce_tx_arbiter #(.SLAVES(SLAVES), .BUSY_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .slave_nonces (slave_nonces),
        .new_nonces   (new_nonces),
        .serial_busy  (serial_busy),
        .golden_nonce (golden_nonce),
        .serial_send  (serial_send),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic strobe(input int unsigned s, input logic [31:0] v);
        @(negedge clk);
        new_nonces    = '0;
        new_nonces[s] = 1'b1;
        slave_nonces[s*32 +: 32] = v;
        @(negedge clk);
        new_nonces = '0;
    endtask

    // Wait until the arbiter and link have been quiet for 8 consecutive cycles.
    task automatic drain(input int unsigned max_cyc);
        int unsigned n = 0;
        int unsigned quiet = 0;
        while (quiet < 8 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (exp_q.size() != 0 || serial_busy || serial_send || pending != '0) quiet = 0;
            else quiet++;
        end
        if (quiet < 8) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // serial_transmit model: busy rises one cycle after the send pulse, lasts 10 cycles.
    initial begin : busy_model
        serial_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_en && serial_send === 1'b1) begin
                @(negedge clk);
                serial_busy = 1'b1;
                repeat (10) @(negedge clk);
                serial_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        prev_send;
        logic [31:0] e;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (serial_send === 1'b1) begin
                n_sends++;
                send_cyc.push_back(cyc);
                chk("send_width", 32'(prev_send), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_send", golden_nonce, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("send_word", golden_nonce, e);
                end
            end
            prev_send = serial_send;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned base;
        int unsigned n;
        reset        = 1'b1;
        new_nonces   = '0;
        slave_nonces = '0;
        repeat (3) @(negedge clk);
        chk("rst_golden", golden_nonce, 32'd0);
        chk("rst_send", 32'(serial_send), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single word, latency one cycle after strobe edge
        @(negedge clk);
        new_nonces[0] = 1'b1;
        slave_nonces[31:0] = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        new_nonces = '0;
        chk("t1_send_e0", 32'(serial_send), 32'd0);
        chk("t1_pend_e0", 32'(pending), 32'd1);
        @(negedge clk);
        chk("t1_send_e1", 32'(serial_send), 32'd1);
        chk("t1_golden", golden_nonce, 32'h1234_5678);
        chk("t1_pend_e1", 32'(pending), 32'd0);
        @(negedge clk);
        chk("t1_send_e2", 32'(serial_send), 32'd0);
        chk("t1_golden_hold", golden_nonce, 32'h1234_5678);
        drain(200);

        // 2: round robin after slave 1 was last served
        exp_q.push_back(32'h0000_000B);
        strobe(1, 32'h0000_000B);
        drain(200);
        @(negedge clk);
        new_nonces = 2'b11;
        slave_nonces = {32'h0000_00B1, 32'h0000_00A1};
        exp_q.push_back(32'h0000_00A1);
        exp_q.push_back(32'h0000_00B1);
        @(negedge clk);
        new_nonces = '0;
        chk("t2_both_pending", 32'(pending), 32'd3);
        drain(200);
        chk("t2_no_overflow", 32'(overflow), 32'd0);

        // 3: third word lands on a full buffer and is dropped
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        strobe(0, 32'h1);
        strobe(0, 32'h2);
        strobe(0, 32'h3);
        chk("t3_overflow_set", 32'(overflow), 32'd1);
        drain(200);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_pending", 32'(pending), 32'd0);

        // 4: no busy response -> timeout returns to IDLE
        busy_en = 1'b0;
        base = send_cyc.size();
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        strobe(0, 32'h55);
        strobe(1, 32'h66);
        drain(200);
        if (send_cyc.size() >= base + 2)
            chk("t4_spacing", send_cyc[base+1] - send_cyc[base], 32'd6);
        else
            chk("t4_send_count", send_cyc.size() - base, 32'd2);
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);
        busy_en = 1'b1;

        // 5: reset while waiting for the link with slave 1 buffered
        exp_q.push_back(32'h77);
        strobe(0, 32'h77);
        n = 0;
        while (!serial_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_busy_seen", 32'(serial_busy), 32'd1);
        strobe(1, 32'h88);
        chk("t5_pending", 32'(pending), 32'd2);
        chk("t5_golden_pre", golden_nonce, 32'h77);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_golden", golden_nonce, 32'd0);
        chk("t5_send", 32'(serial_send), 32'd0);
        chk("t5_pending_rst", 32'(pending), 32'd0);
        chk("t5_overflow_rst", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = n_sends;
        repeat (30) @(negedge clk);
        chk("t5_no_send", n_sends - base, 32'd0);

        // 6: identical word twice
        base = n_sends;
        exp_q.push_back(32'hDEAD);
        strobe(0, 32'hDEAD);
        repeat (20) @(negedge clk);
`ifndef NONCE_DEDUP_EN
        exp_q.push_back(32'hDEAD);
`endif
        strobe(0, 32'hDEAD);
        drain(200);
`ifdef NONCE_DEDUP_EN
        chk("t6_sends", n_sends - base, 32'd1);
`else
        chk("t6_sends", n_sends - base, 32'd2);
`endif
        chk("t6_pending", 32'(pending), 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
